// File: rtl/sobel_stream_filter_if.sv
// sobel_stream_filter_if: raster pixel stream in, edge-magnitude stream out
interface sobel_stream_filter_if #(parameter int DATA_W = 8);
  logic in_valid, in_sof, mode, bin_en, out_valid, out_eol, out_eof;
  logic [DATA_W-1:0] in_pix, thresh, out_pix;
  modport master (output in_valid, in_pix, in_sof, mode, bin_en, thresh,
                  input out_valid, out_pix, out_eol, out_eof);
  modport slave (input in_valid, in_pix, in_sof, mode, bin_en, thresh,
                 output out_valid, out_pix, out_eol, out_eof);
endinterface

// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: 3x3 Sobel edge magnitude over a raster stream, two-stage pipeline
module sobel_stream_filter #(
  parameter int DATA_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic clk,
  input logic rst,
  sobel_stream_filter_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DATA_W + 3;
  logic [CW-1:0] ncol, c;
  logic [RW-1:0] nrow, r;
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [2:0][DATA_W-1:0] ca, cb, cn;
  logic signed [GW-1:0] gx, gy, gx1, gy1;
  logic [DATA_W+1:0] ax, ay, mx;
  logic [DATA_W+2:0] mag;
  logic [DATA_W-1:0] sat, res, th_r;
  logic acc, v1, e1, f1, m_r, b_r;
  function automatic logic signed [GW-1:0] x(input logic [DATA_W-1:0] p);
    return $signed({3'b000, p});
  endfunction
  // cn is the newest window column: [0] row-2, [1] row-1, [2] current row
  always_comb begin
    acc = s.in_valid & ~rst;
    c = s.in_sof ? '0 : ncol;
    r = s.in_sof ? '0 : nrow;
    cn = {s.in_pix, lb1[c], lb2[c]};
    gx = x(cn[0]) - x(ca[0]) + ((x(cn[1]) - x(ca[1])) <<< 1) + x(cn[2]) - x(ca[2]);
    gy = x(ca[0]) - x(ca[2]) + ((x(cb[0]) - x(cb[2])) <<< 1) + x(cn[0]) - x(cn[2]);
    ax = gx1[GW-1] ? (DATA_W+2)'(-gx1) : (DATA_W+2)'(gx1);
    ay = gy1[GW-1] ? (DATA_W+2)'(-gy1) : (DATA_W+2)'(gy1);
    mx = ax > ay ? ax : ay;
    mag = m_r ? {1'b0, mx} : {1'b0, ax} + {1'b0, ay};
    sat = |mag[DATA_W+2:DATA_W] ? '1 : mag[DATA_W-1:0];
    res = b_r ? {DATA_W{sat >= th_r}} : sat;
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[c] <= s.in_pix;
      lb2[c] <= lb1[c];
      ca <= cb;
      cb <= cn;
      gx1 <= gx;
      gy1 <= gy;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ncol <= '0;
      nrow <= '0;
      v1 <= 1'b0;
      e1 <= 1'b0;
      f1 <= 1'b0;
      m_r <= 1'b0;
      b_r <= 1'b0;
      th_r <= '0;
      s.out_valid <= 1'b0;
      s.out_eol <= 1'b0;
      s.out_eof <= 1'b0;
      s.out_pix <= '0;
    end else begin
      v1 <= acc && r >= RW'(2) && c >= CW'(2);
      e1 <= c == CW'(IMG_W - 1);
      f1 <= c == CW'(IMG_W - 1) && r == RW'(IMG_H - 1);
      s.out_valid <= v1;
      s.out_eol <= v1 & e1;
      s.out_eof <= v1 & f1;
      s.out_pix <= v1 ? res : '0;
      if (acc) begin
        ncol <= c == CW'(IMG_W - 1) ? '0 : c + 1'b1;
        nrow <= c == CW'(IMG_W - 1) ? (r == RW'(IMG_H - 1) ? '0 : r + 1'b1) : r;
        if (s.in_sof) {m_r, b_r, th_r} <= {s.mode, s.bin_en, s.thresh};
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb_sobel_stream_filter: directed frames checked against a whole-image Sobel reference
module tb_sobel_stream_filter;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_vec = 0, n_bad = 0;
  bit mon_on = 1'b0;
  int img [6][8];
  typedef struct {logic [7:0] pix; logic eol; logic eof; int t;} res_t;
  res_t got [$];
  res_t exp_q [$];
  sobel_stream_filter_if #(.DATA_W(8)) v ();
  sobel_stream_filter #(.DATA_W(8), .IMG_W(8), .IMG_H(6)) dut (.clk(clk), .rst(rst), .s(v));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mon_on) begin
      if (v.out_valid === 1'b1) got.push_back('{v.out_pix, v.out_eol, v.out_eof, cyc});
      else begin
        n_vec++;
        assert (v.out_eol === 1'b0 && v.out_eof === 1'b0) else begin
          n_bad++;
          $error("FAIL idle_flags: observed eol=%b eof=%b expected 0 0 at cycle %0d", v.out_eol, v.out_eof, cyc);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: observed no end of run, expected completion");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask
  function automatic logic [7:0] ref_px(input int r, input int c, input bit m, input bit b, input logic [7:0] th);
    int gx, gy, ax, ay, mag;
    gx = img[r-1][c+1] - img[r-1][c-1] + 2 * (img[r][c+1] - img[r][c-1]) + img[r+1][c+1] - img[r+1][c-1];
    gy = img[r-1][c-1] - img[r+1][c-1] + 2 * (img[r-1][c] - img[r+1][c]) + img[r-1][c+1] - img[r+1][c+1];
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
    mag = m ? (ax > ay ? ax : ay) : ax + ay;
    if (mag > 255) mag = 255;
    return b ? ((mag >= int'(th)) ? 8'hFF : 8'h00) : 8'(mag);
  endfunction
  task automatic set_img(input int kind);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = kind == 0 ? 100 : kind == 1 ? (c >= 4 ? 255 : 0) : ((r == 2 && c == 2) ? 10 : 0);
  endtask
  task automatic idle1();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [7:0] p, input bit sof, input bit m, input bit b, input logic [7:0] th);
    v.in_valid = 1'b1;
    v.in_pix = p;
    v.in_sof = sof;
    v.mode = m;
    v.bin_en = b;
    v.thresh = th;
    idle1();
    v.in_valid = 1'b0;
    v.in_sof = 1'b0;
  endtask
  // Non-sof pixels carry a conflicting config that must be ignored
  task automatic send_frame(input bit sof, input int npx, input int gmax, input bit m, input bit b, input logic [7:0] th);
    for (int i = 0; i < npx; i++) begin
      int r;
      int c;
      bit first;
      r = i / 8;
      c = i % 8;
      first = sof && i == 0;
      if (gmax > 0) repeat ($urandom_range(gmax, 0)) idle1();
      if (r >= 2 && c >= 2) exp_q.push_back('{ref_px(r - 1, c - 1, m, b, th), c == 7, c == 7 && r == 5, cyc + 2});
      put(8'(img[r][c]), first, first ? m : ~m, first ? b : 1'b1, first ? th : 8'd0);
    end
  endtask
  task automatic check(input string tag);
    chk({tag, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s pix[%0d]", tag, i), {24'd0, got[i].pix}, {24'd0, exp_q[i].pix});
      chk($sformatf("%s eol[%0d]", tag, i), {31'd0, got[i].eol}, {31'd0, exp_q[i].eol});
      chk($sformatf("%s eof[%0d]", tag, i), {31'd0, got[i].eof}, {31'd0, exp_q[i].eof});
      chk($sformatf("%s time[%0d]", tag, i), got[i].t, exp_q[i].t);
    end
    got.delete();
    exp_q.delete();
  endtask
  initial begin
    v.in_valid = 1'b0;
    v.in_pix = '0;
    v.in_sof = 1'b0;
    v.mode = 1'b0;
    v.bin_en = 1'b0;
    v.thresh = '0;
    repeat (3) idle1();
    chk("rst out_valid", {31'd0, v.out_valid}, 0);
    chk("rst out_pix", {24'd0, v.out_pix}, 0);
    chk("rst out_eol", {31'd0, v.out_eol}, 0);
    chk("rst out_eof", {31'd0, v.out_eof}, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    set_img(0);
    send_frame(1'b0, 48, 0, 1'b0, 1'b0, 8'd0);
    repeat (4) idle1();
    chk("const eol 5th", {31'd0, got[4].eol}, 0);
    chk("const eol 6th", {31'd0, got[5].eol}, 1);
    chk("const eof 23rd", {31'd0, got[22].eof}, 0);
    chk("const eof 24th", {31'd0, got[23].eof}, 1);
    check("const");
    set_img(1);
    send_frame(1'b1, 48, 0, 1'b0, 1'b0, 8'd0);
    repeat (4) idle1();
    chk("step0 c2", {24'd0, got[1].pix}, 0);
    chk("step0 c3", {24'd0, got[2].pix}, 255);
    chk("step0 c4", {24'd0, got[3].pix}, 255);
    chk("step0 c5", {24'd0, got[4].pix}, 0);
    check("step0");
    send_frame(1'b1, 48, 0, 1'b1, 1'b0, 8'd0);
    repeat (4) idle1();
    chk("step1 c3", {24'd0, got[2].pix}, 255);
    check("step1");
    set_img(2);
    send_frame(1'b1, 48, 0, 1'b0, 1'b0, 8'd0);
    repeat (4) idle1();
    chk("dot m0", {24'd0, got[0].pix}, 20);
    check("dot m0");
    send_frame(1'b1, 48, 0, 1'b1, 1'b0, 8'd0);
    repeat (4) idle1();
    chk("dot m1", {24'd0, got[0].pix}, 10);
    check("dot m1");
    send_frame(1'b1, 48, 0, 1'b0, 1'b1, 8'd15);
    repeat (4) idle1();
    chk("dot bin m0", {24'd0, got[0].pix}, 255);
    check("dot bin m0");
    send_frame(1'b1, 48, 0, 1'b1, 1'b1, 8'd15);
    repeat (4) idle1();
    chk("dot bin m1", {24'd0, got[0].pix}, 0);
    check("dot bin m1");
    set_img(1);
    send_frame(1'b1, 48, 5, 1'b0, 1'b0, 8'd0);
    repeat (4) idle1();
    check("step gaps");
    // Partial frame up to (3,3); reset lands with pixel (3,4), killing (3,3) in flight
    send_frame(1'b1, 28, 0, 1'b0, 1'b0, 8'd0);
    void'(exp_q.pop_back());
    v.in_valid = 1'b1;
    v.in_pix = 8'd255;
    rst = 1'b1;
    idle1();
    chk("midrst out_valid", {31'd0, v.out_valid}, 0);
    chk("midrst out_pix", {24'd0, v.out_pix}, 0);
    idle1();
    chk("midrst out_valid2", {31'd0, v.out_valid}, 0);
    rst = 1'b0;
    v.in_valid = 1'b0;
    send_frame(1'b1, 48, 0, 1'b0, 1'b0, 8'd0);
    repeat (4) idle1();
    check("mid rst");
    set_img(2);
    send_frame(1'b1, 33, 0, 1'b0, 1'b0, 8'd0);
    send_frame(1'b1, 48, 0, 1'b1, 1'b0, 8'd0);
    repeat (4) idle1();
    chk("abandon m0", {24'd0, got[0].pix}, 20);
    chk("restart m1", {24'd0, got[12].pix}, 10);
    check("mid sof");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
